// File: rtl/synth_pkg.sv
// Shared sample-format constants and the mixer state type for the synth audio path.
package synth_pkg;

    localparam int SAMPLE_W = 24;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StScale,
        StWrite
    } mix_state_t;

endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits, with a clip flag.
module sat_clip #(
    parameter int unsigned IN_W  = 27,
    parameter int unsigned OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    // The value fits only if every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = din[IN_W-1:OUT_W-1];

    always_comb begin
        clip = !((&top_bits) || !(|top_bits));
        if (!clip) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Sums NUM_NOTES voices one per cycle, scales by master_vol and hands a mono sample to the codec.
// VOICE_MIXER_SATURATE_EN selects saturation plus clip counting; otherwise the sample wraps.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int unsigned NUM_NOTES = 6
) (
    input  logic                                     CLOCK_50,
    input  logic                                     reset,
    input  logic signed [NUM_NOTES-1:0][SAMPLE_W-1:0] voices,
    input  logic        [NUM_NOTES-1:0]              voice_mute,
    input  logic        [3:0]                        master_vol,
    input  logic                                     write_ready,
    output logic                                     write,
    output logic signed [SAMPLE_W-1:0]               writedata_left,
    output logic signed [SAMPLE_W-1:0]               writedata_right,
    output logic        [7:0]                        clip_count
);

    localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_NOTES);
    localparam int unsigned IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

    mix_state_t                 state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    addend;
    logic        [IDX_W-1:0]    idx_q;
    logic signed [SAMPLE_W-1:0] voice_sel;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       last_voice;

    assign last_voice = (idx_q == IDX_W'(NUM_NOTES - 1));
    assign voice_sel  = voice_mute[idx_q] ? '0 : voices[idx_q];
    assign addend     = ACC_W'(voice_sel);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (write_ready) state_d = StAccum;
            StAccum: if (last_voice)  state_d = StScale;
            StScale: state_d = StWrite;
            StWrite: if (write_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        write = (state_q == StWrite) && write_ready && !reset;
    end

`ifdef VOICE_MIXER_SATURATE_EN
    logic signed [ACC_W-1:0] scaled;
    logic                    clipped;
    logic [7:0]              clip_q;

    assign scaled = acc_q >>> master_vol;

    sat_clip #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W)
    ) u_sat_clip (
        .din  (scaled),
        .dout (sample_d),
        .clip (clipped)
    );

    // Counter sticks at full scale rather than rolling over.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clip_q <= '0;
        end else if ((state_q == StScale) && clipped && (clip_q != 8'hFF)) begin
            clip_q <= clip_q + 8'd1;
        end
    end

    assign clip_count = clip_q;
`else
    assign sample_d   = SAMPLE_W'(acc_q >>> master_vol);
    assign clip_count = '0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc_q    <= '0;
            idx_q    <= '0;
            sample_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    acc_q <= '0;
                    idx_q <= '0;
                end
                StAccum: begin
                    acc_q <= acc_q + addend;
                    idx_q <= idx_q + IDX_W'(1);
                end
                StScale: sample_q <= sample_d;
                default: ;
            endcase
        end
    end

    assign writedata_left  = sample_q;
    assign writedata_right = sample_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: expected samples are queued at stimulus time and
// popped by a monitor whenever the mixer strobes write.
module tb_voice_mixer;

    localparam int N = 6;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset;
    logic signed [N-1:0][23:0] voices;
    logic        [N-1:0]     voice_mute;
    logic        [3:0]       master_vol;
    logic                    write_ready;
    logic                    write;
    logic signed [23:0]      writedata_left;
    logic signed [23:0]      writedata_right;
    logic        [7:0]       clip_count;

    always #10 CLOCK_50 = ~CLOCK_50;

    voice_mixer #(
        .NUM_NOTES (N)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .voices          (voices),
        .voice_mute      (voice_mute),
        .master_vol      (master_vol),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .clip_count      (clip_count)
    );

    typedef struct {
        int data;
        int clips;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_writes  = 0;
    int   n_pushed  = 0;
    int   exp_clips = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: sum unmuted voices wide, shift, then saturate or wrap.
    task automatic push_expected();
        longint s = 0;
        int     val;
`ifdef VOICE_MIXER_SATURATE_EN
        bit     clipped = 1'b0;
`else
        logic [63:0] u;
`endif
        for (int i = 0; i < N; i++) begin
            if (!voice_mute[i]) s += longint'($signed(voices[i]));
        end
        s = s >>> master_vol;
`ifdef VOICE_MIXER_SATURATE_EN
        if (s > 64'sd8388607) begin
            val = 8388607;
            clipped = 1'b1;
        end else if (s < -64'sd8388608) begin
            val = -8388608;
            clipped = 1'b1;
        end else begin
            val = int'(s);
        end
        if (clipped && exp_clips < 255) exp_clips++;
`else
        u   = s;
        val = int'($signed(u[23:0]));
`endif
        exp_q.push_back('{val, exp_clips});
        n_pushed++;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) voices[i] = v[23:0];
    endtask

    task automatic run_sample(input string tag);
        int lat  = 0;
        bit seen = 1'b0;
        push_expected();
        @(negedge CLOCK_50);
        write_ready = 1'b1;
        while (!seen && lat < 40) begin
            @(negedge CLOCK_50);
            lat++;
            if (write) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? lat : -1, N + 2);
        if (!seen) void'(exp_q.pop_back());
        @(posedge CLOCK_50);
        #1 write_ready = 1'b0;
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (!reset && write) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("left", int'(writedata_left), e.data);
                check("right", int'(writedata_right), e.data);
                check("clip_count", int'(clip_count), e.clips);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, writes %0d", n_writes);
        $fatal(1);
    end

    initial begin
        int held;
        int stall_bad;
        int w0;

        reset       = 1'b1;
        write_ready = 1'b0;
        voices      = '0;
        voice_mute  = '0;
        master_vol  = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_write", int'(write), 0);
        check("rst_left", int'(writedata_left), 0);
        check("rst_right", int'(writedata_right), 0);
        check("rst_clip", int'(clip_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        for (int i = 0; i < N; i++) voices[i] = 24'((i + 1) * 100);
        run_sample("basic");

        set_all(8388607);
        run_sample("all_max");
        set_all(-8388608);
        run_sample("all_min");

        set_all(4096);
        master_vol = 4'd3;
        run_sample("vol3");
        master_vol = 4'd0;
        voice_mute = 6'b000011;
        run_sample("mute");
        voice_mute = '0;

        // Codec back-pressure while the sample is parked in WRITE.
        for (int i = 0; i < N; i++) voices[i] = 24'(i * 1000 - 2500);
        push_expected();
        held = exp_q[$].data;
        @(negedge CLOCK_50);
        write_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 write_ready = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (write || int'(writedata_left) != held) stall_bad++;
            @(negedge CLOCK_50);
        end
        check("stall_quiet", stall_bad, 0);
        @(posedge CLOCK_50);
        #1 write_ready = 1'b1;
        @(negedge CLOCK_50);
        check("stall_write", int'(write), 1);
        @(posedge CLOCK_50);
        #1 write_ready = 1'b0;
        @(negedge CLOCK_50);
        check("stall_single", int'(write), 0);

        // Reset during the third ACCUM cycle abandons the sample.
        for (int i = 0; i < N; i++) voices[i] = 24'(i * 12345 + 7);
        w0 = n_writes;
        @(negedge CLOCK_50);
        write_ready = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset       = 1'b1;
        write_ready = 1'b0;
        @(negedge CLOCK_50);
        check("midrst_write", int'(write), 0);
        check("midrst_left", int'(writedata_left), 0);
        check("midrst_right", int'(writedata_right), 0);
        check("midrst_clip", int'(clip_count), 0);
        reset     = 1'b0;
        exp_clips = 0;
        repeat (15) @(negedge CLOCK_50);
        check("midrst_no_write", n_writes - w0, 0);
        run_sample("after_rst");

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) voices[i] = 24'($urandom);
            voice_mute = 6'($urandom);
            master_vol = 4'($urandom_range(0, 5));
            run_sample("random");
        end
        voice_mute = '0;
        master_vol = '0;

        set_all(8388607);
        for (int k = 0; k < 300; k++) run_sample("clip_run");
        @(negedge CLOCK_50);
        check("clip_sticky", int'(clip_count), exp_clips);

        check("queue_empty", exp_q.size(), 0);
        check("write_count", n_writes, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
